// File: rtl/hex_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package hex_scan_controller_pkg;

  typedef enum logic [0:0] {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } digit_t;

  localparam logic [6:0] SEG_OFF     = 7'h7F;
  localparam digit_t     DIGIT_RESET = '{blank: 1'b1, value: 4'h0};

endpackage

// File: rtl/hex_scan_controller_hexdecode.sv
// Hex nibble to active-low seven-segment pattern, bit 0 = segment a.
module hexDecode
  import hex_scan_controller_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Pure lookup from nibble to segment pattern (gfedcba).
  always_comb begin
    seg_n = SEG_OFF;
    case (hex)
      4'h0:    seg_n = 7'b1000000;
      4'h1:    seg_n = 7'b1111001;
      4'h2:    seg_n = 7'b0100100;
      4'h3:    seg_n = 7'b0110000;
      4'h4:    seg_n = 7'b0011001;
      4'h5:    seg_n = 7'b0010010;
      4'h6:    seg_n = 7'b0000010;
      4'h7:    seg_n = 7'b1111000;
      4'h8:    seg_n = 7'b0000000;
      4'h9:    seg_n = 7'b0010000;
      4'hA:    seg_n = 7'b0001000;
      4'hB:    seg_n = 7'b0000011;
      4'hC:    seg_n = 7'b1000110;
      4'hD:    seg_n = 7'b0100001;
      4'hE:    seg_n = 7'b0000110;
      4'hF:    seg_n = 7'b0001110;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_scan_controller.sv
// Time-multiplexed common-anode seven-segment scanner with a guard gap
// between digits and a single-entry write holding register.
module hex_scan_controller
  import hex_scan_controller_pkg::*;
#(
  parameter  int NUM_DIGITS   = 6,
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLANK_CYCLES = 2,
  localparam int AW           = $clog2(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_blank,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [0:0]    ST_GUARD   = GUARD;
  localparam logic [0:0]    ST_DRIVE   = DRIVE;
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  logic [0:0]            state_r;
  logic [CW-1:0]         cnt_r;
  logic [AW-1:0]         idx_r;
  digit_t                digits_r [NUM_DIGITS];
  logic                  pend_r;
  logic [AW-1:0]         hold_addr_r;
  logic [3:0]            hold_data_r;
  logic                  hold_blank_r;
  logic [6:0]            seg_n_r;
  logic [NUM_DIGITS-1:0] an_n_r;
  logic                  frame_done_r;

  digit_t                cur_digit_s;
  logic [6:0]            dec_seg_s;
  logic                  commit_s;
  logic                  accept_s;
  logic                  addr_ok_s;
  logic                  drive_on_s;
  logic                  drive_end_s;
  logic [NUM_DIGITS-1:0] an_sel_s;

  assign cur_digit_s = digits_r[idx_r];
  assign commit_s    = (state_r == ST_GUARD) && (cnt_r == '0) && pend_r;
  assign accept_s    = wr_valid && !pend_r;
  assign addr_ok_s   = ({{(32-AW){1'b0}}, hold_addr_r} < 32'(NUM_DIGITS));
  assign drive_on_s  = (state_r == ST_DRIVE) && !cur_digit_s.blank;
  assign drive_end_s = (state_r == ST_DRIVE) && (cnt_r == DRIVE_LAST);

  hexDecode u_hex (
    .hex   (cur_digit_s.value),
    .seg_n (dec_seg_s)
  );

  // One-cold anode select for the digit currently being driven.
  always_comb begin
    an_sel_s = '1;
    if (drive_on_s) begin
      an_sel_s[idx_r] = 1'b0;
    end else begin
      an_sel_s = '1;
    end
  end

  // Scan FSM: one shared counter times both the guard gap and the drive window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_GUARD;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_GUARD: begin
          if (cnt_r == GUARD_LAST) begin
            state_r <= ST_DRIVE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_DRIVE: begin
          if (cnt_r == DRIVE_LAST) begin
            state_r <= ST_GUARD;
            cnt_r   <= '0;
            idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + AW'(1'b1);
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r <= ST_GUARD;
          cnt_r   <= '0;
          idx_r   <= '0;
        end
      endcase
    end
  end

  // Holding register and digit file; writes land only at the start of a guard gap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_r       <= 1'b0;
      hold_addr_r  <= '0;
      hold_data_r  <= 4'h0;
      hold_blank_r <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_r[i] <= DIGIT_RESET;
      end
    end else if (commit_s) begin
      pend_r <= 1'b0;
      // Out-of-range addresses are consumed without touching the digit file.
      if (addr_ok_s) begin
        digits_r[hold_addr_r] <= '{blank: hold_blank_r, value: hold_data_r};
      end
    end else if (accept_s) begin
      pend_r       <= 1'b1;
      hold_addr_r  <= wr_addr;
      hold_data_r  <= wr_data;
      hold_blank_r <= wr_blank;
    end
  end

  // Output registers lag the FSM by one cycle in both states, preserving durations.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_n_r      <= SEG_OFF;
      an_n_r       <= '1;
      frame_done_r <= 1'b0;
    end else begin
      seg_n_r      <= drive_on_s ? dec_seg_s : SEG_OFF;
      an_n_r       <= an_sel_s;
      frame_done_r <= drive_end_s && (idx_r == IDX_LAST);
    end
  end

  assign wr_ready   = !pend_r;
  assign seg_n      = seg_n_r;
  assign an_n       = an_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Scoreboard bench: a cycle-indexed display model predicts every output cycle.
module tb_hex_scan_controller;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int DP = SD + BC;

  logic       clock = 1'b0;
  logic       resetn;
  logic       wr_valid, wr_ready, wr_blank, frame_done;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [6:0] seg_n;
  logic [3:0] an_n;

  logic       v5, r5, b5, fd5;
  logic [2:0] a5;
  logic [3:0] d5;
  logic [6:0] seg5;
  logic [4:0] an5;

  int tests = 0;
  int fails = 0;

  hex_scan_controller #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clock(clock), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_blank(wr_blank),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  hex_scan_controller #(.NUM_DIGITS(5), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut5 (
    .clock(clock), .resetn(resetn), .wr_valid(v5), .wr_ready(r5),
    .wr_addr(a5), .wr_data(d5), .wr_blank(b5),
    .seg_n(seg5), .an_n(an5), .frame_done(fd5)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       rdy;
    logic       fd5;
    logic       rdy5;
  } exp_t;

  exp_t expq[$];

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int         cyc;
  bit         m_blank [ND];
  logic [3:0] m_val [ND];
  bit         m_pend, m5_pend;
  int         m_pc, m5_pc, m_pa;
  logic [3:0] m_pd;
  bit         m_pb;

  bit         ghost_en = 1'b0;
  bit         prev_all_hi, seen_drive;
  int         run_len;
  logic [6:0] prev_seg;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: cycle n of a scan is guard for n%DP < BC, else digit (n/DP)%ND;
  // a write taken at cycle t lands at the next multiple of DP strictly after t.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cyc = 0;
      m_pend = 1'b0;
      m5_pend = 1'b0;
      for (int i = 0; i < ND; i++) begin
        m_blank[i] = 1'b1;
        m_val[i] = 4'h0;
      end
      expq.delete();
    end else begin
      exp_t e;
      int p, d;
      bit hs, hs5;
      hs  = wr_valid && !m_pend;
      hs5 = v5 && !m5_pend;
      if (m_pend && cyc == m_pc) begin
        if (m_pa < ND) begin
          m_blank[m_pa] = m_pb;
          m_val[m_pa] = m_pd;
        end
        m_pend = 1'b0;
      end
      if (hs) begin
        m_pend = 1'b1;
        m_pa = int'(wr_addr);
        m_pd = wr_data;
        m_pb = wr_blank;
        m_pc = (cyc / DP + 1) * DP;
      end
      // The 5-digit instance only ever receives out-of-range addresses, so it stays dark.
      if (m5_pend && cyc == m5_pc) m5_pend = 1'b0;
      if (hs5) begin
        m5_pend = 1'b1;
        m5_pc = (cyc / DP + 1) * DP;
      end
      p = cyc % DP;
      d = (cyc / DP) % ND;
      if (p >= BC && !m_blank[d]) begin
        e.seg = hex_tbl[m_val[d]];
        e.an  = ~(4'b0001 << d);
      end else begin
        e.seg = 7'h7F;
        e.an  = 4'hF;
      end
      e.fd   = (cyc % (ND * DP)) == (ND * DP - 1);
      e.rdy  = !m_pend;
      e.fd5  = (cyc % (5 * DP)) == (5 * DP - 1);
      e.rdy5 = !m5_pend;
      expq.push_back(e);
      cyc++;
    end
  end

  // Monitor: pops one expectation per output cycle, plus guard/stability checks.
  always @(negedge clock) begin
    if (!resetn) begin
      check("rst_seg_n", seg_n, 7'h7F);
      check("rst_an_n", an_n, 4'hF);
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_dut5", {seg5, an5, r5, fd5}, {7'h7F, 5'h1F, 1'b1, 1'b0});
    end else if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("seg_n", seg_n, e.seg);
      check("an_n", an_n, e.an);
      check("frame_done", frame_done, e.fd);
      check("wr_ready", wr_ready, e.rdy);
      check("dut5_out", {seg5, an5, r5, fd5}, {7'h7F, 5'h1F, e.rdy5, e.fd5});
    end
    if (!ghost_en) begin
      seen_drive = 1'b0;
      run_len = 0;
    end else if (an_n != 4'hF) begin
      if (!prev_all_hi) check("seg_stable", seg_n, prev_seg);
      else if (seen_drive) check("guard_len", run_len, 2);
      seen_drive = 1'b1;
      run_len = 0;
    end else begin
      run_len++;
    end
    prev_all_hi = (an_n == 4'hF);
    prev_seg = seg_n;
  end

  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic b, output int waited);
    wr_addr = a; wr_data = d; wr_blank = b; wr_valid = 1'b1;
    waited = 0;
    while (!wr_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("wr_handshake", wr_ready, 1'b1);
    @(negedge clock);
  endtask

  task automatic do_write5(input logic [2:0] a, input logic [3:0] d);
    int waited;
    a5 = a; d5 = d; b5 = 1'b0; v5 = 1'b1;
    waited = 0;
    while (!r5 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("wr5_handshake", r5, 1'b1);
    @(negedge clock);
    v5 = 1'b0;
  endtask

  initial begin
    int w;
    resetn = 1'b0;
    wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; wr_blank = 1'b0;
    v5 = 1'b0; a5 = 3'd0; d5 = 4'h0; b5 = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2 * ND * DP + 5) @(negedge clock);

    // Decode of known patterns.
    do_write(2'd0, 4'h0, 1'b0, w);
    do_write(2'd1, 4'h1, 1'b0, w);
    do_write(2'd2, 4'hA, 1'b0, w);
    wr_valid = 1'b0;
    repeat (2 * ND * DP) @(negedge clock);

    // Back-to-back writes with wr_valid held high.
    do_write(2'd3, 4'h7, 1'b0, w);
    do_write(2'd0, 4'hC, 1'b0, w);
    check("bp_stalled", w > 0, 1'b1);
    wr_valid = 1'b0;
    repeat (2 * ND * DP) @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clock);
      do_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), w);
      wr_valid = 1'b0;
    end
    repeat (2 * ND * DP) @(negedge clock);

    // All digits lit, then three frames of ghosting checks.
    for (int i = 0; i < ND; i++) begin
      do_write(2'(i), 4'($urandom_range(0, 15)), 1'b0, w);
    end
    wr_valid = 1'b0;
    repeat (ND * DP + 5) @(negedge clock);
    ghost_en = 1'b1;
    repeat (3 * ND * DP) @(negedge clock);
    ghost_en = 1'b0;

    do_write5(3'd5, 4'h3);
    do_write5(3'd6, 4'h8);
    do_write5(3'd7, 4'hE);
    repeat (2 * 5 * DP) @(negedge clock);

    // Asynchronous reset in the middle of a lit drive window with a write pending.
    w = 0;
    while ((cyc % DP) != 4 && w < 100) begin
      @(negedge clock);
      w++;
    end
    do_write(2'd3, 4'h9, 1'b0, w);
    wr_valid = 1'b0;
    check("pre_reset_lit", an_n != 4'hF, 1'b1);
    check("pre_reset_pending", wr_ready, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check("async_seg_n", seg_n, 7'h7F);
    check("async_an_n", an_n, 4'hF);
    check("async_wr_ready", wr_ready, 1'b1);
    check("async_frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (ND * DP + 5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
